// File: rtl/divu_if.sv
// divu_if: operand/result bundle between the execute stage and divu_seq.
//   master (requester): drives start, Signal, dataA, dataB; observes results.
//   slave  (divider)  : observes the request, drives busy, done, divZero,
//                       quotient (LO) and remainder (HI).
interface divu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       Signal;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic             divZero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, Signal, dataA, dataB,
        input  busy, done, divZero, quotient, remainder
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output busy, done, divZero, quotient, remainder
    );
endinterface

// File: rtl/divu_seq.sv
// divu_seq: multi-cycle unsigned divider (MIPS DIVU) beside the execute-stage ALU.
// One restoring-division step per clock; WIDTH steps per divide.
// Ports:
//   clk    - single clock, rising edge
//   reset  - synchronous, active-high; aborts any operation
//   bus    - divu_if slave: start/Signal/dataA/dataB in;
//            busy/done/divZero/quotient/remainder out
module divu_seq #(
    parameter int         WIDTH = 32,
    parameter logic [5:0] DIVU  = 6'd27
) (
    input  logic  clk,
    input  logic  reset,
    divu_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic        [WIDTH-1:0] q;
    logic        [WIDTH-1:0] rem;
    logic        [WIDTH-1:0] divisor;
    logic        [CNT_W-1:0] cnt;
    logic                    div_zero;
    logic                    accept;
    logic        [WIDTH:0]   t;
    logic                    ge;

    // A request is taken only outside RUN, so a running divide can never be disturbed.
    assign accept = bus.start && (bus.Signal == DIVU) && (state != RUN);

    // Shifted partial remainder; the extra top bit keeps divisors >= 2^(WIDTH-1) exact.
    assign t  = {rem, q[WIDTH-1]};
    assign ge = (t >= {1'b0, divisor});

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = (bus.dataB == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    assign bus.divZero   = div_zero;
    assign bus.quotient  = q;
    assign bus.remainder = rem;

    // Datapath: load at accept, one restoring step per RUN cycle.
    // After the last step q holds the quotient and rem the remainder.
    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            rem      <= '0;
            divisor  <= '0;
            cnt      <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            divisor <= bus.dataB;
            cnt     <= CNT_W'(WIDTH - 1);
            if (bus.dataB == '0) begin
                q        <= '1;
                rem      <= bus.dataA;
                div_zero <= 1'b1;
            end else begin
                q        <= bus.dataA;
                rem      <= '0;
                div_zero <= 1'b0;
            end
        end else if (state == RUN) begin
            q   <= {q[WIDTH-2:0], ge};
            // When ge holds the true difference is below divisor, so WIDTH bits suffice.
            rem <= ge ? (t[WIDTH-1:0] - divisor) : t[WIDTH-1:0];
            cnt <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_divu_seq.sv
// tb_divu_seq: self-checking bench for divu_seq.
// Directed table of operand pairs with hand-computed results, hand-written
// sequences for ignored requests, back-to-back accept and reset abort, and a
// randomized regression against an arithmetic reference model.
module tb_divu_seq;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_bad;

    divu_if #(.WIDTH(32)) bus ();

    divu_seq #(.WIDTH(32), .DIVU(6'd27)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a DIVU request for one edge (the accept edge), then scramble operands.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.Signal = 6'd27;
        bus.dataA  = a;
        bus.dataB  = b;
        tick();
        bus.start  = 1'b0;
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
        bus.Signal = 6'($urandom);
    endtask

    // Count edges after the accept edge until done is seen; bounded.
    task automatic wait_done(output int lat, output int busy_cyc);
        lat      = 0;
        busy_cyc = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cyc++;
            tick();
            lat++;
        end
    endtask

    // Reference: plain arithmetic, with the divide-by-zero convention.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
        if (b == 0) begin
            q  = 32'hFFFFFFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    initial begin
        int          lat;
        int          bc;
        int          lat2;
        int          seen_done;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;

        n_vec      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        bus.dataA  = '0;
        bus.dataB  = '0;

        tbl[0] = '{32'd100,        32'd7,        32'd14,        32'd2,        1'b0};
        tbl[1] = '{32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        1'b0};
        tbl[2] = '{32'h80000000,   32'hFFFFFFFF, 32'd0,         32'h80000000, 1'b0};
        tbl[3] = '{32'hFFFFFFFF,   32'h80000000, 32'd1,         32'h7FFFFFFF, 1'b0};
        tbl[4] = '{32'd5,          32'd0,        32'hFFFFFFFF,  32'd5,        1'b1};
        tbl[5] = '{32'd0,          32'd5,        32'd0,         32'd0,        1'b0};
        tbl[6] = '{32'd1000,       32'd3,        32'd333,       32'd1,        1'b0};

        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dz",   32'(bus.divZero), 32'd0);
        check("rst_q",    bus.quotient, 32'd0);
        check("rst_r",    bus.remainder, 32'd0);
        reset = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 7; i++) begin
            start_op(tbl[i].a, tbl[i].b);
            wait_done(lat, bc);
            check($sformatf("tbl%0d_lat", i), 32'(lat), (tbl[i].b == 0) ? 32'd0 : 32'd32);
            check($sformatf("tbl%0d_busy", i), 32'(bc), (tbl[i].b == 0) ? 32'd0 : 32'd32);
            check($sformatf("tbl%0d_q", i), bus.quotient, tbl[i].q);
            check($sformatf("tbl%0d_r", i), bus.remainder, tbl[i].r);
            check($sformatf("tbl%0d_dz", i), 32'(bus.divZero), 32'(tbl[i].dz));
            check($sformatf("tbl%0d_busy_done", i), 32'(bus.busy), 32'd0);
            tick();
            check($sformatf("tbl%0d_done_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("tbl%0d_q_hold", i), bus.quotient, tbl[i].q);
            check($sformatf("tbl%0d_r_hold", i), bus.remainder, tbl[i].r);
        end

        // Wrong function code is ignored (last result is 1000/3)
        bus.start  = 1'b1;
        bus.Signal = 6'd32;
        bus.dataA  = 32'd123;
        bus.dataB  = 32'd4;
        tick();
        bus.start = 1'b0;
        check("sig32_busy", 32'(bus.busy), 32'd0);
        check("sig32_done", 32'(bus.done), 32'd0);
        tick();
        check("sig32_done2", 32'(bus.done), 32'd0);
        check("sig32_q", bus.quotient, 32'd333);
        check("sig32_r", bus.remainder, 32'd1);

        // Request during RUN is ignored
        start_op(32'd100, 32'd7);
        for (int k = 0; k < 9; k++) tick();
        bus.start  = 1'b1;
        bus.Signal = 6'd27;
        bus.dataA  = 32'd9;
        bus.dataB  = 32'd3;
        tick();
        bus.start = 1'b0;
        wait_done(lat, bc);
        check("midrun_lat", 32'(lat + 10), 32'd32);
        check("midrun_q", bus.quotient, 32'd14);
        check("midrun_r", bus.remainder, 32'd2);

        // Back-to-back: new request accepted on the edge leaving DONE
        start_op(32'd9, 32'd3);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_low", 32'(bus.done), 32'd0);
        wait_done(lat, bc);
        check("b2b_lat", 32'(lat), 32'd32);
        check("b2b_q", bus.quotient, 32'd3);
        check("b2b_r", bus.remainder, 32'd0);
        check("b2b_dz", 32'(bus.divZero), 32'd0);
        tick();

        // Reset abort at RUN cycle 10
        start_op(32'd1000, 32'd3);
        for (int k = 0; k < 9; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_dz", 32'(bus.divZero), 32'd0);
        check("abort_q", bus.quotient, 32'd0);
        check("abort_r", bus.remainder, 32'd0);
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) seen_done++;
            tick();
        end
        check("abort_quiet", 32'(seen_done), 32'd0);
        start_op(32'd1000, 32'd3);
        wait_done(lat, bc);
        check("abort_redo_lat", 32'(lat), 32'd32);
        check("abort_redo_q", bus.quotient, 32'd333);
        check("abort_redo_r", bus.remainder, 32'd1);
        tick();

        // Back-to-back divide-by-zero: done may stay high across both
        start_op(32'd77, 32'd0);
        check("dz2a_done", 32'(bus.done), 32'd1);
        start_op(32'd88, 32'd0);
        check("dz2b_done", 32'(bus.done), 32'd1);
        check("dz2b_r", bus.remainder, 32'd88);
        check("dz2b_busy", 32'(bus.busy), 32'd0);
        tick();

        // Randomized regression
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : 32'($urandom);
            if (i % 5 == 0) ra = ra >> $urandom_range(0, 31);
            if (rb == 0) rb = 32'd1;
            ref_div(ra, rb, eq, er, edz);
            start_op(ra, rb);
            wait_done(lat2, bc);
            check("rnd_lat", 32'(lat2), 32'd32);
            check("rnd_q", bus.quotient, eq);
            check("rnd_r", bus.remainder, er);
            check("rnd_dz", 32'(bus.divZero), 32'(edz));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/divu_seq.md
# divu_seq

Multi-cycle 32-bit unsigned divider (MIPS DIVU, funct 6'd27) that sits beside the combinational 32-bit ALU in the execute stage. The ALU covers the single-cycle funct codes 32/34/36/37/42. This block takes over the long-latency divide: it accepts the same `dataA`/`dataB`/`Signal` operand bus, iterates one restoring-division step per clock, and returns quotient (LO) and remainder (HI) with a done pulse.

## Interface
- `WIDTH`, default 32: operand and result width; the iteration count equals `WIDTH`.
- `DIVU`, default 6'd27: `Signal` code that this block accepts.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on `clk` rising edge.
- `start` input 1: operation request, level-sampled each cycle.
- `Signal` input 6: function code; an operation starts only when it equals `DIVU`.
- `dataA` input 32: dividend, unsigned.
- `dataB` input 32: divisor, unsigned.
- `busy` output 1: high while division iterations are in progress.
- `done` output 1: one-cycle pulse; results are valid from this cycle onward.
- `divZero` output 1: set with `done` when the captured divisor was 0.
- `quotient` output 32: LO result.
- `remainder` output 32: HI result.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **Accept.** A request is accepted on an edge where `start`=1, `Signal`=`DIVU` and the state is IDLE or DONE.
  - `start`=1 with any other `Signal`, or while in RUN, is ignored with no side effects.
- **At accept:**
  - Capture `dataA` into the quotient shift register and `dataB` into the divisor register.
  - Clear the partial remainder.
  - Set the counter to `WIDTH`-1.
  - Clear `divZero`.
- **Accept with divisor ≠ 0:** next state is RUN.
- **Accept with divisor = 0:** next state is DONE directly.
  - Load `quotient` = 32'hFFFFFFFF and `remainder` = the captured dividend.
  - Set `divZero` = 1.
- **Each RUN edge:**
  - Form t = {rem[31:0], q[31]} as a 33-bit value; shift q left by 1.
  - If t ≥ {1'b0, divisor}: rem = t − divisor and q[0] = 1.
  - Otherwise: rem = t[31:0] and q[0] = 0.
  - Use a 33-bit compare and subtract so divisors ≥ 2^31 are handled correctly.
  - Decrement the counter.
  - When the counter is 0 on the edge, go to DONE.
- **DONE:** lasts one cycle, then goes to IDLE unless a new request is accepted on that edge (back-to-back operation allowed).
- **Results:** `quotient`/`remainder` hold the last completed result through IDLE and until the next accept.
  - Intermediate values in RUN are not architecturally meaningful.
- **Operand stability:** operands are sampled only at accept; later changes on `dataA`/`dataB`/`Signal` have no effect.

## Timing
- **Reset values:** state = IDLE, `busy`=0, `done`=0, `divZero`=0, `quotient`=0, `remainder`=0, counter = 0.
- **Reset mid-operation:** reset has priority over everything, including RUN and an accept on the same edge. The operation is aborted with no `done` pulse, and all outputs return to reset values on that edge.
- **Normal latency:**
  - Accept on edge E0.
  - RUN iterations on edges E1..E32.
  - DONE state and `done`=1 in the cycle after E32, i.e. 33 cycles after E0.
- **Divide-by-zero latency:** `done`=1 in the cycle after E0 (1 cycle).
- **`busy`:** 1 exactly in RUN cycles (the 32 cycles after E0); 0 in IDLE and DONE.
  - For divide-by-zero, `busy` never rises.
- **`done`:** registered state decode; never high for two consecutive cycles except on back-to-back divide-by-zero accepts.
- **`divZero`:** holds its value until the next accept.

## Test plan
- **Basic divide.** `dataA`=100, `dataB`=7, `Signal`=27, `start` pulse.
  - `busy` high for 32 cycles, then `done` exactly 33 cycles after accept.
  - `quotient`=14, `remainder`=2, `divZero`=0.
- **Edge-of-range operands.**
  - 32'hFFFFFFFF / 1 → `quotient`=32'hFFFFFFFF, `remainder`=0.
  - 32'h80000000 / 32'hFFFFFFFF → `quotient`=0, `remainder`=32'h80000000.
  - 32'hFFFFFFFF / 32'h80000000 → `quotient`=1, `remainder`=32'h7FFFFFFF.
- **Divide by zero.** `dataA`=5, `dataB`=0.
  - `done` one cycle after accept, `busy` stays 0.
  - `quotient`=32'hFFFFFFFF, `remainder`=5, `divZero`=1.
- **Ignored requests.**
  - `start` with `Signal`=32: no state change.
  - `start` with 9/3 at cycle 10 of a running 100/7: ignored; result stays 14 r 2.
  - New 9/3 accepted in the DONE cycle: next `done` 33 cycles later with 3 r 0.
- **Reset abort.** `reset` asserted at RUN cycle 10 of 1000/3.
  - `busy`/`done`/`divZero`=0 and `quotient`/`remainder`=0 next cycle; no `done` pulse.
  - A following 1000/3 returns 333 r 1.
- **Random regression.** 1000 random unsigned pairs with divisor ≠ 0, checked against `dataA`/`dataB` and `dataA`%`dataB` with fixed 33-cycle latency.
